// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the core top level:
// default widths and the loader state encoding.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;
    localparam int IMEM_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } loader_state_t;

    function automatic logic state_is_busy(input loader_state_t s);
        return (s == LOAD) || (s == RUN);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a program from the host into instruction memory, releases the core
// from reset, then watches its PC and a cycle budget to decide when the run ends.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W,
    parameter int CNT_W  = IMEM_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [DATA_W-1:0] o_im_wdata,
    output logic              o_core_rst,
    input  logic [ADDR_W-1:0] i_core_pc,
    input  logic [ADDR_W-1:0] i_halt_pc,
    input  logic [CNT_W-1:0]  i_limit,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_cycles
);

    loader_state_t     r_state;
    loader_state_t     w_state_next;

    logic [ADDR_W:0]   r_word_cnt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_halt_pc;
    logic [CNT_W-1:0]  r_limit;
    logic [CNT_W-1:0]  r_cycles;

    logic              r_in_ready;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [DATA_W-1:0] r_im_wdata;
    logic              r_core_rst;
    logic              r_done;
    logic              r_err;

    logic              w_idle_like;
    logic              w_start_ok;
    logic              w_start_bad;
    logic              w_transfer;
    logic              w_last_word;
    logic              w_in_run;
    logic              w_pc_hit;
    logic              w_timeout;

    assign w_idle_like = (r_state == IDLE) || (r_state == HALT);
    assign w_start_ok  = w_idle_like && i_start && !i_abort && (i_len != '0);
    assign w_start_bad = w_idle_like && i_start && !i_abort && (i_len == '0);
    assign w_transfer  = (r_state == LOAD) && r_in_ready && i_in_valid && !i_abort;
    // Counter is one bit wider than the address so a full-memory load ends cleanly.
    assign w_last_word = (r_word_cnt == (r_len - 1'b1));
    assign w_in_run    = (r_state == RUN) && !i_abort;
    assign w_pc_hit    = w_in_run && (i_core_pc == r_halt_pc);
    assign w_timeout   = w_in_run && (r_limit != '0) && (r_cycles == (r_limit - 1'b1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_abort) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (w_start_ok) begin
                        w_state_next = LOAD;
                    end else if (w_start_bad) begin
                        w_state_next = IDLE;
                    end
                end
                LOAD: begin
                    if (w_transfer && w_last_word) begin
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (w_pc_hit || w_timeout) begin
                        w_state_next = HALT;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Host-side handshake and the memory write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_word_cnt <= '0;
        end else begin
            r_in_ready <= (w_state_next == LOAD);
            r_im_we    <= w_transfer;
            if (w_start_ok) begin
                r_word_cnt <= '0;
            end else if (w_transfer) begin
                r_im_addr  <= r_word_cnt[ADDR_W-1:0];
                r_im_wdata <= i_in_data;
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    // Run parameters captured at START.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len     <= '0;
            r_halt_pc <= '0;
            r_limit   <= '0;
        end else if (w_start_ok) begin
            r_len     <= i_len;
            r_halt_pc <= i_halt_pc;
            r_limit   <= i_limit;
        end
    end

    // Core reset stays high on any edge that enters or leaves RUN, so the core
    // never sees a partially loaded memory and is parked the moment a run ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_core_rst <= 1'b1;
        end else begin
            r_core_rst <= (r_state != RUN) || (w_state_next != RUN);
        end
    end

    // Run accounting: saturating cycle count and the done/error verdict.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycles <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_cycles <= '0;
                r_done   <= 1'b0;
                r_err    <= 1'b0;
            end else if (w_start_bad) begin
                r_err    <= 1'b1;
            end else if (w_in_run) begin
                if (r_cycles != '1) begin
                    r_cycles <= r_cycles + 1'b1;
                end
                if (w_pc_hit) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_core_rst = r_core_rst;
    assign o_busy     = state_is_busy(r_state);
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_cycles   = r_cycles;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a driver pushes expected writes and
// run outcomes, a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] core_pc = '0;
    logic [AW-1:0] halt_pc = '0;
    logic [CW-1:0] limit = '0;

    logic          o_in_ready;
    logic          o_im_we;
    logic [AW-1:0] o_im_addr;
    logic [DW-1:0] o_im_wdata;
    logic          o_core_rst;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [CW-1:0] o_cycles;

    imem_loader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_len      (len),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .o_in_ready (o_in_ready),
        .o_im_we    (o_im_we),
        .o_im_addr  (o_im_addr),
        .o_im_wdata (o_im_wdata),
        .o_core_rst (o_core_rst),
        .i_core_pc  (core_pc),
        .i_halt_pc  (halt_pc),
        .i_limit    (limit),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_cycles   (o_cycles)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } wr_t;

    typedef struct {
        logic          done;
        logic          err;
        logic [CW-1:0] cycles;
        logic          chk_cycles;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  mon_w;
    res_t mon_r;
    logic prev_busy = 1'b0;

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] prog [256];

    function automatic void check(input string name, input longint act, input longint want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [AW-1:0] pc_at(input logic [AW-1:0] pc0, input logic [AW-1:0] step, input int k);
        return AW'(int'(pc0) + int'(step) * k);
    endfunction

    // First RUN cycle k in which the run must end, and whether it ends in error.
    function automatic void model_run(input logic [AW-1:0] hpc, input logic [CW-1:0] lim,
                                      input logic [AW-1:0] pc0, input logic [AW-1:0] step,
                                      output int k_stop, output logic err);
        k_stop = -1;
        err = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (pc_at(pc0, step, k) == hpc) begin
                k_stop = k;
                err = 1'b0;
                return;
            end
            if (lim != 0 && k == int'(lim) - 1) begin
                k_stop = k;
                err = 1'b1;
                return;
            end
        end
    endfunction

    function automatic logic [CW-1:0] sat_cnt(input int v);
        int top;
        top = (1 << CW) - 1;
        return (v > top) ? CW'(top) : CW'(v);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (o_im_we) begin
            if (wq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", o_im_addr, o_im_wdata);
            end else begin
                mon_w = wq.pop_front();
                check("wr_addr", o_im_addr, mon_w.addr);
                check("wr_data", o_im_wdata, mon_w.data);
                check("wr_cycle", cyc, mon_w.cyc);
                check("wr_core_rst", o_core_rst, 1);
            end
        end
        if (prev_busy && !o_busy) begin
            if (rq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_stop: busy dropped, expected still busy");
            end else begin
                mon_r = rq.pop_front();
                check("stop_done", o_done, mon_r.done);
                check("stop_err", o_err, mon_r.err);
                check("stop_core_rst", o_core_rst, 1);
                if (mon_r.chk_cycles) check("stop_cycles", o_cycles, mon_r.cycles);
            end
        end
        prev_busy = o_busy;
    end

    // ---------------- driver ----------------
    task automatic run_program(input int len_i, input int vmode, input logic [AW-1:0] hpc,
                               input logic [CW-1:0] lim, input logic [AW-1:0] pc0,
                               input logic [AW-1:0] step, input int abort_at);
        int   k_halt;
        int   stop_k;
        int   idx;
        int   t;
        logic exp_err;
        bit   hs;
        bit   aborting;
        model_run(hpc, lim, pc0, step, k_halt, exp_err);
        aborting = (abort_at >= 0) && (abort_at < k_halt);
        stop_k = aborting ? abort_at : k_halt;

        @(posedge clk); #1;
        start = 1'b1;
        len = (AW+1)'(len_i);
        halt_pc = hpc;
        limit = lim;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_ready", o_in_ready, 1);
        check("load_busy", o_busy, 1);
        check("load_cycles_clr", o_cycles, 0);
        check("load_flags_clr", {o_done, o_err}, 0);

        idx = 0;
        t = 0;
        while (idx < len_i) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = 1'($urandom_range(0, 1));
                default: in_valid = ((t % 4) == 0) || ((t % 4) == 3);
            endcase
            in_data = in_valid ? prog[idx] : $urandom;
            hs = in_valid && o_in_ready;
            if (hs) wq.push_back('{idx, prog[idx], cyc + 1});
            @(posedge clk); #1;
            if (hs) idx++;
            t++;
            if (t > 3000) begin
                checks++;
                $display("FAIL load_timeout: %0d words accepted, expected %0d", idx, len_i);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        check("run_ready_drop", o_in_ready, 0);
        check("run_core_rst_hold", o_core_rst, 1);
        if (!aborting) rq.push_back('{1'b1, exp_err, sat_cnt(k_halt + 1), 1'b1});

        for (int k = 0; k <= 600; k++) begin
            core_pc = pc_at(pc0, step, k);
            if (k == 1) check("core_rst_release", o_core_rst, 0);
            if (aborting && k == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                len = 9'd3;
                rq.push_back('{1'b0, 1'b0, '0, 1'b0});
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            if (!o_busy) begin
                check("stop_cycle", k, stop_k);
                break;
            end
            if (k == 600) begin
                checks++;
                $display("FAIL run_timeout: still busy after %0d cycles, expected stop at %0d", k, stop_k);
            end
        end
        if (aborting) begin
            check("abort_ready", o_in_ready, 0);
            check("abort_im_we", o_im_we, 0);
        end
        @(negedge clk); #1;
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) prog[i] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3 rst_n = 1'b0;
        #4;
        check("rst_ready", o_in_ready, 0);
        check("rst_im_we", o_im_we, 0);
        check("rst_core_rst", o_core_rst, 1);
        check("rst_busy", o_busy, 0);
        check("rst_flags", {o_done, o_err}, 0);
        check("rst_cycles", o_cycles, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Three-word program, always valid, long run that saturates the cycle count
        prog[0] = 32'h00500093;
        prog[1] = 32'h00100113;
        prog[2] = 32'h002081B3;
        run_program(3, 0, 8'h10, 4'd0, 8'h00, 8'h01, -1);

        // Valid pattern 1,0,0,1 on a two-word load
        fill_random(2);
        run_program(2, 2, 8'h03, 4'd0, 8'h00, 8'h01, -1);

        // PC match after five RUN cycles
        fill_random(4);
        run_program(4, 1, 8'h08, 4'd0, 8'h00, 8'h02, -1);

        // Timeout, then timeout coinciding with PC match
        fill_random(3);
        run_program(3, 0, 8'hFF, 4'd4, 8'h00, 8'h02, -1);
        run_program(3, 0, 8'h06, 4'd4, 8'h00, 8'h02, -1);

        // Zero-length START
        @(posedge clk); #1;
        start = 1'b1;
        len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_err", o_err, 1);
        check("len0_busy", o_busy, 0);
        check("len0_ready", o_in_ready, 0);
        repeat (3) @(posedge clk);
        #1 check("len0_no_write", o_im_we, 0);

        // ABORT during RUN with a simultaneous START
        fill_random(2);
        run_program(2, 0, 8'hFF, 4'd10, 8'h00, 8'h02, 2);

        // ABORT beats START from IDLE
        @(posedge clk); #1;
        abort = 1'b1;
        start = 1'b1;
        len = 9'd3;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_beats_start", o_busy, 0);
        check("abort_beats_start_rdy", o_in_ready, 0);

        // Full-memory load
        fill_random(256);
        run_program(256, 1, 8'h05, 4'd3, 8'h00, 8'h01, -1);

        // Randomized programs
        for (int n = 0; n < 8; n++) begin
            int ln;
            ln = $urandom_range(1, 24);
            fill_random(ln);
            run_program(ln, $urandom_range(0, 2), AW'($urandom), CW'($urandom),
                        AW'($urandom), AW'($urandom) | 8'h01,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1);
        end

        // Asynchronous reset in the middle of a load, after word 1
        fill_random(4);
        @(posedge clk); #1;
        start = 1'b1;
        len = 9'd4;
        halt_pc = 8'h00;
        limit = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1;
            in_data = prog[w];
            wq.push_back('{w, prog[w], cyc + 1});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        rq.push_back('{1'b0, 1'b0, '0, 1'b1});
        #1;
        check("mid_rst_ready", o_in_ready, 0);
        check("mid_rst_im_we", o_im_we, 0);
        check("mid_rst_addr", o_im_addr, 0);
        check("mid_rst_wdata", o_im_wdata, 0);
        check("mid_rst_core_rst", o_core_rst, 1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_flags", {o_done, o_err}, 0);
        check("mid_rst_cycles", o_cycles, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", o_busy, 0);
        check("post_rst_ready", o_in_ready, 0);
        @(negedge clk); #1;
        check("final_wq_drained", wq.size(), 0);
        check("final_rq_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, is the instruction-memory address width; it matches the core PC width.
REQ-002 Parameter DATA_W, default 32, is the instruction word width.
REQ-003 Parameter CNT_W, default 16, is the run-cycle counter width.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  one-cycle pulse; begins a load of LEN words.
REQ-007 ABORT  in  1  level; returns the block to IDLE.
REQ-008 LEN  in  ADDR_W+1  program length in words, 1..2^ADDR_W; sampled with START.
REQ-009 IN_DATA  in  DATA_W  instruction word from the host.
REQ-010 IN_VALID  in  1  host word valid.
REQ-011 IN_READY  out  1  loader accepts a word.
REQ-012 IM_WE  out  1  instruction-memory write strobe.
REQ-013 IM_ADDR  out  ADDR_W  instruction-memory write address.
REQ-014 IM_WDATA  out  DATA_W  instruction-memory write data.
REQ-015 CORE_RST  out  1  active-high reset to the processor core.
REQ-016 CORE_PC  in  ADDR_W  current core PC.
REQ-017 HALT_PC  in  ADDR_W  PC value that terminates a run; sampled with START.
REQ-018 LIMIT  in  CNT_W  maximum run cycles, 0 = unlimited; sampled with START.
REQ-019 BUSY, DONE, ERR  out  1 each  status flags; CYCLES  out  CNT_W  run-cycle count.

Function
REQ-020 The FSM SHALL have four states: IDLE, LOAD, RUN and HALT.
REQ-021 IDLE or HALT with START=1 and LEN=0: the FSM stays or moves to IDLE and sets ERR=1.
REQ-022 IDLE or HALT with START=1 and LEN!=0: the FSM goes to LOAD, clears ERR, DONE and CYCLES, zeroes the word counter, and latches LEN, HALT_PC and LIMIT.
REQ-023 START in LOAD or RUN SHALL be ignored.
REQ-024 IN_READY SHALL be a registered output that is 1 only while the state is LOAD; a transfer is IN_VALID & IN_READY at a rising edge.
REQ-025 On each transfer: IM_WE=1, IM_ADDR = word counter and IM_WDATA = IN_DATA in the following cycle; the word counter increments.
REQ-026 IM_WE SHALL be 0 in every cycle that does not follow a transfer.
REQ-027 The transfer of word LEN-1 (counter == LEN-1) moves the FSM to RUN at the same edge and drops IN_READY.
REQ-028 CORE_RST SHALL be registered as (state != RUN), so it is 1 during the final IM_WE cycle and 0 from the second edge after the final transfer.
REQ-029 In RUN, CYCLES SHALL increment by 1 per cycle and saturate at 2^CNT_W-1.
REQ-030 RUN -> HALT when CORE_PC == latched HALT_PC (normal end: DONE=1, ERR=0).
REQ-031 RUN -> HALT when LIMIT!=0 and CYCLES == LIMIT-1 (timeout: DONE=1, ERR=1).
REQ-032 If the PC match and the timeout occur in the same cycle, the PC match SHALL win and ERR SHALL stay 0.
REQ-033 In HALT, CORE_RST=1 and CYCLES holds its final value.
REQ-034 ABORT=1 in any state SHALL force IDLE at the next edge with CORE_RST=1, IN_READY=0 and IM_WE=0; DONE and ERR are unchanged; ABORT has priority over START.
REQ-035 BUSY SHALL equal (state == LOAD or state == RUN).
REQ-036 LEN = 2^ADDR_W SHALL write addresses 0..2^ADDR_W-1; the word counter is ADDR_W+1 bits wide, so there is no premature wrap.

Reset
REQ-037 While RST=0: state=IDLE, IN_READY=0, IM_WE=0, IM_ADDR=0, IM_WDATA=0, CORE_RST=1, BUSY=0, DONE=0, ERR=0, CYCLES=0, all latches 0.
REQ-038 Assertion of RST mid-load or mid-run SHALL take effect immediately (asynchronously); the loader restarts only on a new START after RST is released.

Structure
REQ-039 A shared package SHALL hold the state enumeration and the ADDR_W/DATA_W/CNT_W defaults, shared with the core top level.
REQ-040 No sub-module is required; the FSM, word counter and saturating cycle counter are inline.

Verification
REQ-041 LEN=3, words 0x00500093/0x00100113/0x002081B3, IN_VALID always 1 -> IM_WE at addresses 0,1,2 on consecutive cycles; CORE_RST falls 2 edges after the third transfer.
REQ-042 IN_VALID toggled 1,0,0,1 during a LEN=2 load -> exactly 2 writes, no IM_WE in the gap cycles.
REQ-043 HALT_PC=0x08, CORE_PC reaches 0x08 after 5 RUN cycles -> DONE=1, ERR=0, CYCLES=5, CORE_RST=1.
REQ-044 LIMIT=4, HALT_PC never reached -> HALT after 4 RUN cycles with ERR=1; a separate case with the PC match on that same cycle -> ERR=0.
REQ-045 START with LEN=0 -> ERR=1, state IDLE, no IM_WE; RST pulled low mid-LOAD after word 1 -> all outputs at reset values within the same cycle.
REQ-046 ABORT during RUN -> IDLE next edge, CORE_RST=1; START in the same cycle as ABORT is ignored.
